// File: rtl/uart_receiver.sv
// 8N1 UART receiver: two-flop RX synchronizer, mid-bit sampling FSM,
// one-cycle VALID / FRAME_ERR pulses and a held DATA register.
`timescale 1ns/1ps
module uart_receiver #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX,
  output logic [7:0] DATA,
  output logic       VALID,
  output logic       FRAME_ERR,
  output logic       BUSY
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t      state_q;
  logic [15:0] cnt_q;
  logic [2:0]  idx_q;
  logic [7:0]  shift_q;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        ferr_q;
  logic        rx_meta_q;
  logic        rxs_q;

  // Both flops reset high so a reset never looks like a start edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rxs_q     <= rx_meta_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!rxs_q) begin
            state_q <= S_START;
            cnt_q   <= '0;
          end
        end
        S_START: begin
          // A start bit that is high again at its centre is a glitch.
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            idx_q <= '0;
            state_q <= rxs_q ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_DATA: begin
          if (cnt_q == BIT_LAST) begin
            shift_q[idx_q] <= rxs_q;
            cnt_q          <= '0;
            if (idx_q == 3'd7) begin
              state_q <= S_STOP;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_STOP: begin
          // Leaving at the stop-bit centre leaves half a bit to catch the next start edge.
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            if (rxs_q) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= S_WAIT_HIGH;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_WAIT_HIGH: begin
          if (rxs_q) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign DATA      = data_q;
  assign VALID     = valid_q;
  assign FRAME_ERR = ferr_q;
  assign BUSY      = (state_q != S_IDLE);

endmodule
